// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares the single-port word RAM between the fetch and data ports.
//            One transaction owns the RAM at a time. Data has priority over
//            fetch unless ARB_ROUND_ROBIN_EN is defined, which alternates
//            contended grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_ren,
    input  logic [31:0] i_addr,
    output logic [31:0] i_load,
    output logic [1:0]  i_state,
    input  logic        d_ren,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_store,
    output logic [31:0] d_load,
    output logic [1:0]  d_state,
    output logic        m_ren,
    output logic [3:0]  m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_store,
    input  logic [31:0] m_load,
    input  logic [1:0]  m_state,
    output logic        err
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    localparam logic [1:0] RAM_IDLE = 2'd0;
    localparam logic [1:0] RAM_WAIT = 2'd1;
    localparam logic [1:0] RAM_DONE = 2'd2;
    localparam int         CW       = $clog2(MAX_WAIT + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic          rr_q, rr_d;      // 1: data wins the next contended grant
`endif

    logic w_i_req, w_d_req, w_sel_data, w_grant, w_busy;

    assign w_i_req = i_ren;
    assign w_d_req = d_ren | (|d_wen);
    assign w_busy  = (state_q != ARB_IDLE);
    assign err     = err_q & nrst;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        w_sel_data = 1'b0;
        w_grant    = 1'b0;
        i_state    = w_i_req ? RAM_WAIT : RAM_IDLE;
        d_state    = w_d_req ? RAM_WAIT : RAM_IDLE;
        i_load     = '0;
        d_load     = '0;

        unique case (state_q)
            ARB_IDLE: begin
                cnt_d   = '0;
                w_grant = w_i_req | w_d_req;
                if (w_i_req && w_d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w_sel_data = rr_q;
                    rr_d       = ~rr_q;
`else
                    w_sel_data = 1'b1;
`endif
                end else begin
                    w_sel_data = w_d_req;
                end
                if (w_grant) begin
                    state_d = w_sel_data ? ARB_D : ARB_I;
                end
            end
            ARB_I: begin
                w_grant = 1'b1;
                i_state = m_state;
                i_load  = m_load;
                if (m_state == RAM_DONE || !w_i_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_D: begin
                w_grant    = 1'b1;
                w_sel_data = 1'b1;
                d_state    = m_state;
                d_load     = m_load;
                if (m_state == RAM_DONE || !w_d_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Error latches in the same edge the saturating counter reaches MAX_WAIT
        if (w_busy && m_state != RAM_DONE) begin
            if (cnt_q != CW'(MAX_WAIT)) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_q == CW'(MAX_WAIT - 1)) begin
                err_d = 1'b1;
            end
        end

        m_ren   = 1'b0;
        m_wen   = '0;
        m_addr  = '0;
        m_store = '0;
        if (w_grant && nrst) begin
            if (w_sel_data) begin
                m_ren   = d_ren;
                m_wen   = d_wen;
                m_addr  = d_addr;
                m_store = d_store;
            end else begin
                m_ren   = i_ren;
                m_addr  = i_addr;
            end
        end

        // Reset drops ownership immediately, not just at the next edge
        if (!nrst) begin
            i_state = RAM_IDLE;
            d_state = RAM_IDLE;
            i_load  = '0;
            d_load  = '0;
        end
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port word RAM between the core's instruction-fetch port and its data (load/store) port. Each requester sees the same request/state handshake the RAM exposes: `ren`, `wen`, `addr`, `store`, `load` and a `ram_state_t` status. The arbiter owns the RAM port for one whole transaction at a time. It sits between the fetch/memory stages and the RAM instance, and adds no cycles to an uncontended access.

## Interface
- MAX_WAIT, 16: cycles a granted transaction may stay in flight before the watchdog error is flagged.
- clk  in  1  clock
- nrst  in  1  reset nrst, synchronous, active-low
- i_ren  in  1  fetch read request
- i_addr  in  32  fetch byte address
- i_load  out  32  fetch read data
- i_state  out  2  fetch status (ram_state_t: RAM_IDLE/RAM_WAIT/RAM_DONE)
- d_ren  in  1  data read request
- d_wen  in  4  data byte write enables
- d_addr  in  32  data byte address
- d_store  in  32  data write data
- d_load  out  32  data read data
- d_state  out  2  data status (ram_state_t)
- m_ren, m_wen[4], m_addr[32], m_store[32]  out  RAM-side request, driven from the granted requester
- m_load  in  32  RAM read data
- m_state  in  2  RAM status (ram_state_t)
- err  out  1  sticky watchdog error

## Operation
- FSM states: ARB_IDLE, ARB_I (fetch owns the RAM), ARB_D (data owns the RAM).
- Request definitions:
  - i_req = i_ren.
  - d_req = d_ren | (|d_wen).
- ARB_IDLE:
  - The winner is chosen combinationally and its signals drive m_* in the same cycle.
  - The FSM moves to ARB_I or ARB_D on the next edge.
  - With no request, all m_* outputs are 0.
- Arbitration when both i_req and d_req are asserted: data wins by default (fixed priority). See Configuration for the round-robin alternative.
- ARB_I / ARB_D:
  - m_* is muxed from the owner.
  - The owner's state output and load are forwarded from m_state/m_load.
  - When m_state == RAM_DONE, the FSM returns to ARB_IDLE on the next edge. The owner's request is still muxed to the RAM during that DONE cycle.
- Abort: if the owner deasserts its request before RAM_DONE, the FSM returns to ARB_IDLE on the next edge, and the RAM sees its request drop in that same cycle.
- Non-owner outputs:
  - state = RAM_WAIT if its request is asserted, otherwise RAM_IDLE.
  - load = 0.
- Watchdog:
  - An in-flight counter resets to 0 on entry to ARB_I/ARB_D and increments each busy cycle.
  - If it reaches MAX_WAIT without RAM_DONE, err is set to 1 and stays set until reset.
  - The counter saturates; arbitration is otherwise unaffected.
- Reset (synchronous, nrst=0):
  - FSM goes to ARB_IDLE; counter = 0; err = 0.
  - The round-robin pointer favours data next.
  - Reset mid-transaction drops ownership immediately.

## Timing
- Uncontended access requested in cycle t: owner state = RAM_DONE in cycle t+LAT+1, where LAT is the RAM latency. Load data is valid in that same cycle.
- Back-to-back transactions:
  - The next grant is issued in the cycle after DONE, which is when the RAM counter is back at 0.
  - There is no additional bubble.
- Losing requester under contention: waits until the cycle after the owner's DONE, then is granted in ARB_IDLE.
- Reset values while nrst=0 and in the following ARB_IDLE with no requests:
  - i_state = d_state = RAM_IDLE.
  - i_load = d_load = 0.
  - m_ren = 0, m_wen = 0, m_addr = 0, m_store = 0.
  - err = 0.
- Requester rule: addr/store/wen must be held stable from request until DONE.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: on contention in ARB_IDLE, the requester that did not win the previous contended grant wins. The pointer updates only on contended grants.
  - Undefined: fixed data-over-fetch priority; the pointer logic is not compiled.

## Test plan
- Lone fetch, i_ren=1, i_addr=0x40, RAM holds 0xDEADBEEF, LAT=0 -> i_state WAIT in cycle 0, DONE with i_load=0xDEADBEEF in cycle 1; d_state RAM_IDLE throughout.
- Same-cycle i_ren and d_wen=4'hF, d_addr=0x80, d_store=0x12345678 -> data granted first; i_state WAIT until the cycle after data DONE, then fetch completes; RAM[0x80>>2]=0x12345678.
- Fetch held continuously and data requested continuously for 4 transactions -> without the macro, data wins all 4 contended grants; with ARB_ROUND_ROBIN_EN, grants alternate D,I,D,I.
- Owner drops d_ren one cycle after grant (LAT=3) -> ARB_IDLE next cycle; pending fetch granted the cycle after that and completes normally.
- RAM model forced to never return DONE, MAX_WAIT=16 -> err rises exactly 16 busy cycles after grant and stays 1; nrst=0 for one edge clears err and returns all outputs to reset values.
- nrst asserted mid data transaction -> m_* = 0 and d_state RAM_IDLE after the edge; the first post-reset contended grant goes to data.
